// File: rtl/alu_issue.sv
// Issue/decode stage for the 8-bit ALU: decodes 9-bit instructions into registered
// ALU command/register fields and stalls read-after-write hazards against writeback.
module alu_issue #(
  parameter int WB_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  instr_i,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [3:0]  alu_cmd,
  output logic [2:0]  ra_addr,
  output logic [2:0]  rb_addr,
  output logic [2:0]  wr_addr,
  output logic        wr_en,
  output logic        is_branch,
  output logic        out_valid,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] stall_cnt
);

  // Handshake: instr_i transfers on a rising edge where in_valid && in_ready.
  // Fetch holds instr_i stable while in_valid is high and in_ready is low;
  // in_ready never depends on in_valid, only on state, flush and instr_i sources.

  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_next;

  logic [3:0] op;
  logic [2:0] r_fld;
  logic       unused_bits;
  assign op          = instr_i[8:5];
  assign r_fld       = instr_i[4:2];
  assign unused_bits = ^instr_i[1:0];

  logic [3:0] d_cmd;
  logic [2:0] d_ra, d_rb, d_wr;
  logic       d_wen, d_br, d_issue, d_illegal, d_halt;
  logic       src_r, src_r0;

  always_comb begin
    d_cmd     = 4'd0;
    d_ra      = 3'd0;
    d_rb      = 3'd0;
    d_wr      = 3'd0;
    d_wen     = 1'b0;
    d_br      = 1'b0;
    d_issue   = 1'b0;
    d_illegal = 1'b0;
    d_halt    = 1'b0;
    src_r     = 1'b0;
    src_r0    = 1'b0;
    case (op)
      4'h0: d_issue = 1'b1;
      4'h1, 4'h3, 4'h4, 4'h5: begin
        d_issue = 1'b1;
        d_cmd   = op;
        d_ra    = r_fld;
        d_wen   = 1'b1;
        src_r   = 1'b1;
        src_r0  = 1'b1;
      end
      4'h2: begin
        d_issue = 1'b1;
        d_cmd   = op;
        d_ra    = r_fld;
        d_br    = 1'b1;
        src_r   = 1'b1;
      end
      4'h6: begin
        d_issue = 1'b1;
        d_cmd   = op;
        d_wr    = r_fld;
        d_wen   = 1'b1;
        src_r0  = 1'b1;
      end
      4'h7: begin
        d_issue = 1'b1;
        d_cmd   = op;
        d_ra    = r_fld;
        d_wen   = 1'b1;
        src_r   = 1'b1;
      end
      4'h8: begin
        d_issue = 1'b1;
        d_cmd   = op;
        d_rb    = r_fld;
        d_wen   = 1'b1;
        src_r   = 1'b1;
      end
      4'hF:    d_halt    = 1'b1;
      default: d_illegal = 1'b1;
    endcase
  end

  // Writeback history: entry i holds a destination written i+1 edges ago.
  logic [WB_LAT-1:0] hist_v;
  logic [2:0]        hist_dst [WB_LAT];
  logic              hazard;
  logic              fire;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (hist_v[i] && ((src_r && hist_dst[i] == r_fld) || (src_r0 && hist_dst[i] == 3'd0)))
        hazard = 1'b1;
    end
  end

  assign in_ready = (state == RUN) && !hazard && !flush;
  assign fire     = in_valid && in_ready;
  assign halted   = (state == HALTED);

  always_comb begin
    state_next = state;
    if (state == RUN && fire && d_halt) state_next = HALTED;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_v <= '0;
      for (int i = 0; i < WB_LAT; i++) hist_dst[i] <= 3'd0;
    end else begin
      hist_v[0]   <= fire && d_wen;
      hist_dst[0] <= (fire && d_wen) ? d_wr : 3'd0;
      for (int i = 1; i < WB_LAT; i++) begin
        hist_v[i]   <= hist_v[i-1];
        hist_dst[i] <= hist_dst[i-1];
      end
    end
  end

  // Fields hold their last issued value; only out_valid marks them as fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      alu_cmd   <= 4'd0;
      ra_addr   <= 3'd0;
      rb_addr   <= 3'd0;
      wr_addr   <= 3'd0;
      wr_en     <= 1'b0;
      is_branch <= 1'b0;
      illegal   <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      out_valid <= fire && d_issue;
      if (fire && d_issue) begin
        alu_cmd   <= d_cmd;
        ra_addr   <= d_ra;
        rb_addr   <= d_rb;
        wr_addr   <= d_wr;
        wr_en     <= d_wen;
        is_branch <= d_br;
      end
      if (fire && d_illegal) illegal <= 1'b1;
      if (state == RUN && in_valid && hazard && !flush && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: two instances (WB_LAT 2 and 4), directed scenarios plus
// randomized streams checked against a register-availability model.
module tb_alu_issue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [2];
  logic [8:0]  instr_i   [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        flush     [2];
  logic [3:0]  alu_cmd   [2];
  logic [2:0]  ra_addr   [2];
  logic [2:0]  rb_addr   [2];
  logic [2:0]  wr_addr   [2];
  logic        wr_en     [2];
  logic        is_branch [2];
  logic        out_valid [2];
  logic        halted    [2];
  logic        illegal   [2];
  logic [15:0] stall_cnt [2];

  alu_issue #(.WB_LAT(2)) dut0 (
    .clk(clk), .reset(reset[0]), .instr_i(instr_i[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .flush(flush[0]), .alu_cmd(alu_cmd[0]), .ra_addr(ra_addr[0]),
    .rb_addr(rb_addr[0]), .wr_addr(wr_addr[0]), .wr_en(wr_en[0]), .is_branch(is_branch[0]),
    .out_valid(out_valid[0]), .halted(halted[0]), .illegal(illegal[0]), .stall_cnt(stall_cnt[0])
  );

  alu_issue #(.WB_LAT(4)) dut1 (
    .clk(clk), .reset(reset[1]), .instr_i(instr_i[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .flush(flush[1]), .alu_cmd(alu_cmd[1]), .ra_addr(ra_addr[1]),
    .rb_addr(rb_addr[1]), .wr_addr(wr_addr[1]), .wr_en(wr_en[1]), .is_branch(is_branch[1]),
    .out_valid(out_valid[1]), .halted(halted[1]), .illegal(illegal[1]), .stall_cnt(stall_cnt[1])
  );

  // Field word: {cmd[14:11], ra[10:8], rb[7:5], wr[4:2], wen[1], br[0]}
  localparam logic [14:0] F_ADD_R3 = {4'h3, 3'd3, 3'd0, 3'd0, 1'b1, 1'b0};
  localparam logic [14:0] F_BNE_R5 = {4'h2, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1};
  localparam logic [14:0] F_XOR_R2 = {4'h1, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0};
  localparam logic [14:0] F_XOR_R1 = {4'h1, 3'd1, 3'd0, 3'd0, 1'b1, 1'b0};
  localparam logic [14:0] F_MOV_R6 = {4'h6, 3'd0, 3'd0, 3'd6, 1'b1, 1'b0};
  localparam logic [14:0] F_PAR_R6 = {4'h8, 3'd0, 3'd6, 3'd0, 1'b1, 1'b0};

  int n_cmp = 0;
  int n_err = 0;
  int tb_edge = 0;

  // Observed values
  logic        obs_ready, obs_ov, obs_halted, obs_illegal;
  logic [14:0] obs_f;
  logic [15:0] obs_stall;

  // Reference model: last edge at which each register was targeted by a writer.
  int          m_edge;
  int          m_last_wr [8];
  bit          m_halted, m_illegal, m_ready, m_ov;
  int          m_stall;
  logic [14:0] exp_q [$];

  typedef struct packed {
    logic        issue;
    logic        halt;
    logic        ill;
    logic        rd_r;
    logic        rd_r0;
    logic [14:0] f;
  } dec_t;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic dec_t ref_decode(input logic [8:0] ins);
    dec_t       x;
    logic [3:0] op;
    logic [2:0] r;
    op = ins[8:5];
    r  = ins[4:2];
    x  = '0;
    x.issue    = (op <= 4'd8);
    x.halt     = (op == 4'hF);
    x.ill      = !x.issue && !x.halt;
    x.rd_r0    = op inside {4'd1, 4'd3, 4'd4, 4'd5, 4'd6};
    x.rd_r     = op inside {[4'd1:4'd5], 4'd7, 4'd8};
    x.f[14:11] = x.issue ? op : 4'd0;
    x.f[10:8]  = (op inside {[4'd1:4'd5], 4'd7}) ? r : 3'd0;
    x.f[7:5]   = (op == 4'd8) ? r : 3'd0;
    x.f[4:2]   = (op == 4'd6) ? r : 3'd0;
    x.f[1]     = op inside {4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    x.f[0]     = (op == 4'd2);
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_last_wr[i] = -1000;
    m_halted  = 0;
    m_illegal = 0;
    m_stall   = 0;
    m_ov      = 0;
    exp_q.delete();
  endtask

  // A source is readable once its writer is more than lat edges old.
  task automatic model_step(input int lat, input logic [8:0] ins, input bit valid, input bit fl);
    dec_t x;
    int   nxt;
    bit   haz, acc;
    x   = ref_decode(ins);
    nxt = m_edge + 1;
    haz = (x.rd_r && nxt <= m_last_wr[ins[4:2]] + lat) || (x.rd_r0 && nxt <= m_last_wr[0] + lat);
    m_ready = !m_halted && !haz && !fl;
    acc     = valid && m_ready;
    if (!m_halted && valid && haz && !fl && m_stall < 65535) m_stall++;
    m_ov = acc && x.issue;
    if (m_ov) exp_q.push_back(x.f);
    if (m_ov && x.f[1]) m_last_wr[x.f[4:2]] = nxt;
    if (acc && x.ill) m_illegal = 1;
    if (acc && x.halt) m_halted = 1;
    m_edge = nxt;
  endtask

  task automatic sample(input int d);
    obs_ov      = out_valid[d];
    obs_f       = {alu_cmd[d], ra_addr[d], rb_addr[d], wr_addr[d], wr_en[d], is_branch[d]};
    obs_halted  = halted[d];
    obs_illegal = illegal[d];
    obs_stall   = stall_cnt[d];
  endtask

  // One clock: inputs driven 1 time unit after posedge, ready sampled mid-cycle,
  // registered outputs sampled 1 time unit after the next posedge.
  task automatic cycle(input int d, input logic [8:0] ins, input bit valid, input bit fl);
    instr_i[d]  = ins;
    in_valid[d] = valid;
    flush[d]    = fl;
    model_step(lat_of(d), ins, valid, fl);
    #3;
    obs_ready = in_ready[d];
    @(posedge clk);
    #1;
    tb_edge++;
    sample(d);
  endtask

  // Pulses reset for one edge, leaving instr_i/in_valid/flush as they are.
  task automatic do_reset(input int d);
    reset[d] = 1'b1;
    @(posedge clk);
    #1;
    reset[d] = 1'b0;
    tb_edge++;
    m_edge++;
    model_reset();
    sample(d);
  endtask

  function automatic logic [8:0] rand_instr();
    logic [3:0] op;
    logic [2:0] r;
    logic [1:0] lo;
    op = ($urandom_range(0, 99) < 6) ? 4'($urandom_range(9, 14)) : 4'($urandom_range(0, 8));
    r  = 3'($urandom_range(0, 3));
    lo = 2'($urandom_range(0, 3));
    return {op, r, lo};
  endfunction

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      instr_i[d]  = 9'h0;
      in_valid[d] = 1'b0;
      flush[d]    = 1'b0;
      do_reset(d);
      n_cmp++;
      if ({obs_ov, obs_f, obs_halted, obs_illegal, obs_stall} !== 34'd0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got ov=%b f=%h h=%b ill=%b stall=%0d, want all 0",
                 d, obs_ov, obs_f, obs_halted, obs_illegal, obs_stall);
      end
      cycle(d, 9'h000, 1'b0, 1'b0);
      n_cmp++;
      if (obs_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_ready dut%0d: got %b want 1", d, obs_ready);
      end
    end
  endtask

  task automatic test_independent();
    do_reset(0);
    cycle(0, 9'h06C, 1'b1, 1'b0);
    n_cmp++;
    if ({obs_ready, obs_ov, obs_f} !== {1'b1, 1'b1, F_ADD_R3}) begin
      n_err++;
      $display("FAIL indep_add: got rdy=%b ov=%b f=%h, want rdy=1 ov=1 f=%h",
               obs_ready, obs_ov, obs_f, F_ADD_R3);
    end
    cycle(0, 9'h054, 1'b1, 1'b0);
    n_cmp++;
    if ({obs_ready, obs_ov, obs_f} !== {1'b1, 1'b1, F_BNE_R5}) begin
      n_err++;
      $display("FAIL indep_bne: got rdy=%b ov=%b f=%h, want rdy=1 ov=1 f=%h",
               obs_ready, obs_ov, obs_f, F_BNE_R5);
    end
    cycle(0, 9'h000, 1'b0, 1'b0);
    n_cmp++;
    if ({obs_ov, obs_stall} !== {1'b0, 16'd0}) begin
      n_err++;
      $display("FAIL indep_idle: got ov=%b stall=%0d, want ov=0 stall=0", obs_ov, obs_stall);
    end
  endtask

  // Writer followed by a dependent reader: reader stalls exactly WB_LAT cycles.
  task automatic test_raw(input int d, input logic [8:0] wr_ins, input logic [14:0] wr_f,
                          input logic [8:0] rd_ins, input logic [14:0] rd_f);
    int lat, e_wr, lows, n;
    bit got;
    lat  = lat_of(d);
    lows = 0;
    n    = 0;
    got  = 0;
    do_reset(d);
    cycle(d, wr_ins, 1'b1, 1'b0);
    e_wr = tb_edge;
    n_cmp++;
    if ({obs_ov, obs_f} !== {1'b1, wr_f}) begin
      n_err++;
      $display("FAIL raw_writer dut%0d: got ov=%b f=%h want ov=1 f=%h", d, obs_ov, obs_f, wr_f);
    end
    while (!got && n < 20) begin
      cycle(d, rd_ins, 1'b1, 1'b0);
      n++;
      if (obs_ready) got = 1;
      else lows++;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL raw_timeout dut%0d: reader not accepted in 20 cycles", d);
    end
    n_cmp++;
    if (lows != lat) begin
      n_err++;
      $display("FAIL raw_stall_cycles dut%0d: got %0d want %0d", d, lows, lat);
    end
    n_cmp++;
    if ({obs_ov, obs_f} !== {1'b1, rd_f}) begin
      n_err++;
      $display("FAIL raw_reader dut%0d: got ov=%b f=%h want ov=1 f=%h", d, obs_ov, obs_f, rd_f);
    end
    n_cmp++;
    if (tb_edge - e_wr != lat + 1) begin
      n_err++;
      $display("FAIL raw_gap dut%0d: got %0d want %0d", d, tb_edge - e_wr, lat + 1);
    end
    n_cmp++;
    if (obs_stall !== 16'(lat)) begin
      n_err++;
      $display("FAIL raw_stall_cnt dut%0d: got %0d want %0d", d, obs_stall, lat);
    end
    cycle(d, 9'h000, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    do_reset(0);
    cycle(0, 9'h064, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 9'h024, 1'b1, 1'b1);
      n_cmp++;
      if ({obs_ready, obs_ov, obs_stall} !== {1'b0, 1'b0, 16'd0}) begin
        n_err++;
        $display("FAIL flush_hold[%0d]: got rdy=%b ov=%b stall=%0d, want 0 0 0",
                 i, obs_ready, obs_ov, obs_stall);
      end
    end
    cycle(0, 9'h024, 1'b1, 1'b0);
    n_cmp++;
    if ({obs_ready, obs_ov, obs_f, obs_stall} !== {1'b1, 1'b1, F_XOR_R1, 16'd0}) begin
      n_err++;
      $display("FAIL flush_release: got rdy=%b ov=%b f=%h stall=%0d, want 1 1 %h 0",
               obs_ready, obs_ov, obs_f, obs_stall, F_XOR_R1);
    end
    cycle(0, 9'h000, 1'b0, 1'b0);
  endtask

  task automatic test_illegal_halt();
    do_reset(0);
    cycle(0, 9'h120, 1'b1, 1'b0);
    n_cmp++;
    if ({obs_ready, obs_ov, obs_illegal, obs_halted} !== 4'b1010) begin
      n_err++;
      $display("FAIL illegal_op: got rdy=%b ov=%b ill=%b h=%b, want 1 0 1 0",
               obs_ready, obs_ov, obs_illegal, obs_halted);
    end
    cycle(0, 9'h1E0, 1'b1, 1'b0);
    n_cmp++;
    if ({obs_ready, obs_ov, obs_illegal, obs_halted} !== 4'b1011) begin
      n_err++;
      $display("FAIL halt_op: got rdy=%b ov=%b ill=%b h=%b, want 1 0 1 1",
               obs_ready, obs_ov, obs_illegal, obs_halted);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 9'h06C, 1'b1, 1'b0);
      n_cmp++;
      if ({obs_ready, obs_ov, obs_halted} !== 3'b001) begin
        n_err++;
        $display("FAIL halted_block[%0d]: got rdy=%b ov=%b h=%b, want 0 0 1",
                 i, obs_ready, obs_ov, obs_halted);
      end
    end
    do_reset(0);
    n_cmp++;
    if ({obs_halted, obs_illegal} !== 2'b00) begin
      n_err++;
      $display("FAIL halt_reset: got h=%b ill=%b want 0 0", obs_halted, obs_illegal);
    end
    // Halt right behind a writer: no sources, so no stall.
    do_reset(1);
    cycle(1, 9'h06C, 1'b1, 1'b0);
    cycle(1, 9'h1E0, 1'b1, 1'b0);
    n_cmp++;
    if ({obs_ready, obs_halted, obs_stall} !== {1'b1, 1'b1, 16'd0}) begin
      n_err++;
      $display("FAIL halt_hazard: got rdy=%b h=%b stall=%0d, want 1 1 0",
               obs_ready, obs_halted, obs_stall);
    end
    instr_i[1]  = 9'h000;
    in_valid[1] = 1'b0;
    do_reset(1);
  endtask

  task automatic test_reset_mid_stall();
    do_reset(1);
    cycle(1, 9'h06C, 1'b1, 1'b0);
    cycle(1, 9'h028, 1'b1, 1'b0);
    cycle(1, 9'h028, 1'b1, 1'b0);
    n_cmp++;
    if ({obs_ready, obs_stall} !== {1'b0, 16'd2}) begin
      n_err++;
      $display("FAIL midstall_pre: got rdy=%b stall=%0d want 0 2", obs_ready, obs_stall);
    end
    do_reset(1);
    n_cmp++;
    if ({obs_ov, obs_f, obs_halted, obs_illegal, obs_stall} !== 34'd0) begin
      n_err++;
      $display("FAIL midstall_outputs: got ov=%b f=%h h=%b ill=%b stall=%0d, want all 0",
               obs_ov, obs_f, obs_halted, obs_illegal, obs_stall);
    end
    cycle(1, 9'h028, 1'b1, 1'b0);
    n_cmp++;
    if ({obs_ready, obs_ov, obs_f} !== {1'b1, 1'b1, F_XOR_R2}) begin
      n_err++;
      $display("FAIL midstall_after: got rdy=%b ov=%b f=%h want 1 1 %h",
               obs_ready, obs_ov, obs_f, F_XOR_R2);
    end
    cycle(1, 9'h000, 1'b0, 1'b0);
  endtask

  task automatic test_random(input int d);
    logic [8:0]  cur;
    logic [14:0] want;
    bit          cur_v, fl;
    do_reset(d);
    cur   = rand_instr();
    cur_v = 1;
    for (int i = 0; i < 250; i++) begin
      fl = ($urandom_range(0, 5) == 0);
      cycle(d, cur, cur_v, fl);
      n_cmp++;
      if (obs_ready !== m_ready) begin
        n_err++;
        $display("FAIL rand_ready dut%0d i=%0d ins=%h: got %b want %b", d, i, cur, obs_ready, m_ready);
      end
      n_cmp++;
      if (obs_ov !== m_ov) begin
        n_err++;
        $display("FAIL rand_ov dut%0d i=%0d ins=%h: got %b want %b", d, i, cur, obs_ov, m_ov);
      end
      if (m_ov && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        n_cmp++;
        if (obs_f !== want) begin
          n_err++;
          $display("FAIL rand_fields dut%0d i=%0d ins=%h: got %h want %h", d, i, cur, obs_f, want);
        end
      end
      n_cmp++;
      if ({obs_illegal, obs_halted, obs_stall} !== {m_illegal, m_halted, 16'(m_stall)}) begin
        n_err++;
        $display("FAIL rand_status dut%0d i=%0d: got ill=%b h=%b stall=%0d want %b %b %0d",
                 d, i, obs_illegal, obs_halted, obs_stall, m_illegal, m_halted, m_stall);
      end
      if (!cur_v || obs_ready) begin
        cur   = rand_instr();
        cur_v = ($urandom_range(0, 4) != 0);
      end
    end
    instr_i[d]  = 9'h000;
    in_valid[d] = 1'b0;
    flush[d]    = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d]    = 1'b1;
      instr_i[d]  = 9'h000;
      in_valid[d] = 1'b0;
      flush[d]    = 1'b0;
    end
    m_edge = 0;
    model_reset();
    test_reset();
    test_independent();
    test_raw(0, 9'h06C, F_ADD_R3, 9'h028, F_XOR_R2);
    test_raw(1, 9'h06C, F_ADD_R3, 9'h028, F_XOR_R2);
    test_raw(0, 9'h0D8, F_MOV_R6, 9'h118, F_PAR_R6);
    test_raw(1, 9'h0D8, F_MOV_R6, 9'h118, F_PAR_R6);
    test_flush();
    test_illegal_halt();
    test_reset_mid_stall();
    test_random(0);
    test_random(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
